// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller: access size codes,
// FSM states and the alignment rule.
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_HALF = 2'b10,
    SZ_BYTE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_WORD: is_misaligned = (lo != 2'b00);
      SZ_HALF: is_misaligned = lo[0];
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: byte enables and replicated store data for a request,
// plus lane extraction and sign extension of a returned load word.
module dmem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_rep,
  output logic [31:0] load_ext
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel  = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    byte_sel  = load_word[{addr_lo, 3'b000} +: 8];
    byte_en   = '0;
    store_rep = store_data;
    load_ext  = load_word;
    case (size)
      SZ_WORD: byte_en = 4'b1111;
      SZ_HALF: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{store_data[15:0]}};
        load_ext  = {{16{half_sel[15]}}, half_sel};
      end
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        store_rep = {4{store_data[7:0]}};
        load_ext  = {{24{byte_sel[7]}}, byte_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences EX/MEM data accesses onto a req/ack memory port, stalling the
// pipeline until the access completes, times out, or is dropped as misaligned.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  MemRead,
  input  logic [1:0]  MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] RData2,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBE,
  output logic        Stall,
  output logic        LoadValid,
  output logic [31:0] LoadData,
  output logic        AlignErr,
  output logic        BusErr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  size_e            sz_q;
  logic [1:0]       off_q;

  size_e       acc_sz, lane_sz;
  logic        acc_we, acc_present, acc_misaligned, go, tmo;
  logic [1:0]  lane_off;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_ldata;

  always_comb begin
    acc_we         = (MemWrite != 2'b00);
    acc_sz         = size_e'(acc_we ? MemWrite : MemRead);
    acc_present    = (acc_sz != SZ_NONE);
    acc_misaligned = is_misaligned(acc_sz, ALUResult[1:0]);
    tmo            = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // One aligner serves both directions: stores are formed in IDLE from the
  // live request, loads are extracted in REQ from the latched size/offset.
  assign lane_sz  = (state_q == IDLE) ? acc_sz : sz_q;
  assign lane_off = (state_q == IDLE) ? ALUResult[1:0] : off_q;

  dmem_lane_align u_lane (
    .size       (lane_sz),
    .addr_lo    (lane_off),
    .store_data (RData2),
    .load_word  (MemRData),
    .byte_en    (lane_be),
    .store_rep  (lane_wdata),
    .load_ext   (lane_ldata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    Stall    = 1'b0;
    AlignErr = 1'b0;
    go       = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_present) begin
          if (acc_misaligned) begin
            AlignErr = 1'b1;
          end else begin
            Stall   = 1'b1;
            go      = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        Stall = 1'b1;
        if (MemAck || tmo) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      MemReq    <= 1'b0;
      MemWe     <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
      MemBE     <= '0;
      LoadData  <= '0;
      LoadValid <= 1'b0;
      BusErr    <= 1'b0;
      cnt_q     <= '0;
      sz_q      <= SZ_NONE;
      off_q     <= '0;
    end else begin
      LoadValid <= 1'b0;
      BusErr    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            MemReq   <= 1'b1;
            MemWe    <= acc_we;
            MemAddr  <= {ALUResult[31:2], 2'b00};
            MemBE    <= lane_be;
            MemWData <= lane_wdata;
            sz_q     <= acc_sz;
            off_q    <= ALUResult[1:0];
            cnt_q    <= '0;
          end
        end
        REQ: begin
          if (MemAck) begin
            MemReq <= 1'b0;
            if (!MemWe) begin
              LoadData  <= lane_ldata;
              LoadValid <= 1'b1;
            end
          end else if (tmo) begin
            MemReq   <= 1'b0;
            LoadData <= '0;
            BusErr   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed accesses push expected
// requests/responses; a negedge monitor pops and compares them.
module tb_dmem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  MemRead, MemWrite;
  logic [31:0] ALUResult, RData2, MemRData;
  logic        MemAck;
  logic        MemReq, MemWe, Stall, LoadValid, AlignErr, BusErr;
  logic [31:0] MemAddr, MemWData, LoadData;
  logic [3:0]  MemBE;

  always #5 Clk = ~Clk;

  dmem_access_ctrl #(.TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .RData2(RData2), .MemAck(MemAck), .MemRData(MemRData),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemBE(MemBE), .Stall(Stall), .LoadValid(LoadValid), .LoadData(LoadData),
    .AlignErr(AlignErr), .BusErr(BusErr)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    logic [2:0]  flags;  // {LoadValid, BusErr, AlignErr}
    logic [31:0] data;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compares each new request and each response pulse.
  initial begin
    logic req_prev;
    req_t r;
    rsp_t s;
    req_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (MemReq && !req_prev) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr 0x%08h expected no request", MemAddr);
        end else begin
          r = exp_req.pop_front();
          check("req_we",    32'(MemWe), 32'(r.we));
          check("req_addr",  MemAddr,    r.addr);
          check("req_be",    32'(MemBE), 32'(r.be));
          check("req_wdata", MemWData,   r.wd);
        end
      end
      req_prev = MemReq;
      if (LoadValid || BusErr || AlignErr) begin
        if (exp_rsp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got flags %b expected none", {LoadValid, BusErr, AlignErr});
        end else begin
          s = exp_rsp.pop_front();
          check("rsp_flags", 32'({LoadValid, BusErr, AlignErr}), 32'(s.flags));
          if (s.flags[0]) begin
            check("align_stall", 32'(Stall), 32'd0);
            check("align_req",   32'(MemReq), 32'd0);
          end else begin
            check("rsp_data", LoadData, s.data);
          end
        end
      end
    end
  end

  // Presents one access for one IDLE cycle and holds it while stalled.
  // ack_after = REQ cycles before the ack cycle (large = never).
  task automatic access(input string nm, input logic [1:0] rd, input logic [1:0] wr,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                        input int ack_after, input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [2:0] eflags, input logic [31:0] eld,
                        input int estall, input int ereqc);
    int stalls = 0;
    int reqc = 0;
    bit done = 0;
    req_t r;
    rsp_t s;
    if (estall > 0) begin
      r.we = (wr != 2'b00); r.addr = {addr[31:2], 2'b00}; r.wd = ewd; r.be = ebe;
      exp_req.push_back(r);
    end
    if (eflags != 3'b000) begin
      s.flags = eflags; s.data = eld;
      exp_rsp.push_back(s);
    end
    MemRead = rd; MemWrite = wr; ALUResult = addr; RData2 = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      MemAck = 1'b0;
      if (!Stall) begin done = 1; break; end
      stalls++;
      if (MemReq) begin
        if (reqc == ack_after) begin MemAck = 1'b1; MemRData = rdat; end
        reqc++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no release after 100 cycles expected release", nm);
    end
    check({nm, "_stall"}, 32'(stalls), 32'(estall));
    check({nm, "_reqc"},  32'(reqc),   32'(ereqc));
    if (estall > 0) check({nm, "_lv"}, 32'(LoadValid), 32'(eflags[2]));
    @(posedge Clk); #1;
    MemRead = 2'b00; MemWrite = 2'b00; ALUResult = '0; RData2 = '0; MemAck = 1'b0;
  endtask

  initial begin
    req_t r;
    Reset = 1'b1; MemRead = '0; MemWrite = '0; ALUResult = '0; RData2 = '0;
    MemAck = 1'b0; MemRData = '0;
    repeat (2) @(negedge Clk);
    check("rst_req",   32'(MemReq),    32'd0);
    check("rst_we",    32'(MemWe),     32'd0);
    check("rst_addr",  MemAddr,        32'd0);
    check("rst_wdata", MemWData,       32'd0);
    check("rst_be",    32'(MemBE),     32'd0);
    check("rst_ld",    LoadData,       32'd0);
    check("rst_lv",    32'(LoadValid), 32'd0);
    check("rst_buserr",32'(BusErr),    32'd0);
    check("rst_stall", 32'(Stall),     32'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    //      name        rd     wr     addr          wdata         rdata         ack  be       ewd           flags   eld           stall reqc
    access("wload",    2'b01, 2'b00, 32'h100, 32'h0,        32'hDEADBEEF, 0,  4'b1111, 32'h0,        3'b100, 32'hDEADBEEF, 2,  1);
    access("bstore",   2'b00, 2'b11, 32'h203, 32'h000000A5, 32'h0,        0,  4'b1000, 32'hA5A5A5A5, 3'b000, 32'h0,        2,  1);
    access("hload",    2'b10, 2'b00, 32'h302, 32'h0,        32'h8001FFFF, 3,  4'b1100, 32'h0,        3'b100, 32'hFFFF8001, 5,  4);
    access("misw",     2'b01, 2'b00, 32'h101, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        3'b001, 32'h0,        0,  0);
    access("mish",     2'b10, 2'b00, 32'h003, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        3'b001, 32'h0,        0,  0);
    access("hstore",   2'b00, 2'b10, 32'h012, 32'h1234ABCD, 32'h0,        1,  4'b1100, 32'hABCDABCD, 3'b000, 32'h0,        3,  2);
    access("wrwins",   2'b01, 2'b11, 32'h001, 32'h00000077, 32'h0,        0,  4'b0010, 32'h77777777, 3'b000, 32'h0,        2,  1);
    access("bload",    2'b11, 2'b00, 32'h501, 32'h0,        32'h12348056, 0,  4'b0010, 32'h0,        3'b100, 32'hFFFFFF80, 2,  1);
    access("tmo",      2'b01, 2'b00, 32'h400, 32'h0,        32'h0,        1000, 4'b1111, 32'h0,      3'b010, 32'h0,        17, 16);

    // Late ack after the timeout must be ignored.
    MemAck = 1'b1; MemRData = 32'hCAFEF00D;
    @(negedge Clk);
    MemAck = 1'b0;
    @(negedge Clk);
    check("late_ack_req", 32'(MemReq),    32'd0);
    check("late_ack_lv",  32'(LoadValid), 32'd0);
    check("late_ack_ld",  LoadData,       32'd0);

    // Reset in the middle of REQ.
    @(posedge Clk); #1;
    r.we = 1'b0; r.addr = 32'h600; r.wd = 32'h0; r.be = 4'b1111;
    exp_req.push_back(r);
    MemRead = 2'b01; ALUResult = 32'h600;
    repeat (3) @(negedge Clk);
    check("mid_req_active", 32'(MemReq), 32'd1);
    Reset = 1'b1; MemRead = 2'b00; ALUResult = '0;
    @(negedge Clk);
    check("mid_rst_req",   32'(MemReq),    32'd0);
    check("mid_rst_stall", 32'(Stall),     32'd0);
    check("mid_rst_addr",  MemAddr,        32'd0);
    check("mid_rst_be",    32'(MemBE),     32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    MemAck = 1'b1; MemRData = 32'h11111111;
    @(negedge Clk);
    MemAck = 1'b0;
    check("post_rst_ack_lv", 32'(LoadValid), 32'd0);
    check("post_rst_req",    32'(MemReq),    32'd0);
    @(posedge Clk); #1;

    access("rload",    2'b01, 2'b00, 32'h700, 32'h0,        32'h0BADF00D, 0,  4'b1111, 32'h0,        3'b100, 32'h0BADF00D, 2,  1);
    access("rstore",   2'b00, 2'b11, 32'h702, 32'h0000005A, 32'h0,        0,  4'b0100, 32'h5A5A5A5A, 3'b000, 32'h0,        2,  1);

    repeat (3) @(negedge Clk);
    check("req_q_empty", 32'(exp_req.size()), 32'd0);
    check("rsp_q_empty", 32'(exp_rsp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
